// File: rtl/fc_sched_pkg.sv
// Shared types and defaults for the FC-layer ping-pong scheduler.
package fc_sched_pkg;

    localparam int M_DEF       = 5;
    localparam int N_DEF       = 2;
    localparam int MAC_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

    // Address width for a range of v values, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fc_xbuf_loader.sv
// Load side of the ping-pong x buffer: write counter, write bank and per-bank full flags.
module fc_xbuf_loader
    import fc_sched_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int LOGN = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            input_valid,
    input  logic            release_en,
    input  logic            release_bank,
    output logic            input_ready,
    output logic            wr_en_x,
    output logic            wr_bank,
    output logic [LOGN-1:0] addr_x_wr,
    output logic [1:0]      bank_full
);

    logic [LOGN-1:0] wr_cnt;
    logic            wr_bank_q;
    logic [1:0]      full_q;
    logic [1:0]      full_n;
    logic            accept;
    logic            last_elem;

    assign input_ready = !reset && !full_q[wr_bank_q];
    assign accept      = input_valid && input_ready;
    assign last_elem   = (wr_cnt == LOGN'(N - 1));
    assign wr_en_x     = accept;
    assign addr_x_wr   = wr_cnt;
    assign wr_bank     = wr_bank_q;
    assign bank_full   = full_q;

    // Fill and release in one cycle always target opposite banks, so both apply.
    always_comb begin
        full_n = full_q;
        if (release_en) full_n[release_bank] = 1'b0;
        if (accept && last_elem) full_n[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt    <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= 2'b00;
        end else begin
            full_q <= full_n;
            if (accept) begin
                if (last_elem) begin
                    wr_cnt    <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fc_pingpong_sched.sv
// Sequencing controller for one FC-layer MAC datapath with a ping-pong x buffer.
// Defining FC_PERF_CNT_EN adds the stall_cycles counter and its perf_clr input.
module fc_pingpong_sched
    import fc_sched_pkg::*;
#(
    parameter int M       = M_DEF,
    parameter int N       = N_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    localparam int LOGN = clog2_min1(N),
    localparam int LOGW = clog2_min1(M * N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            input_valid,
    output logic            input_ready,
    output logic            output_valid,
    input  logic            output_ready,
    output logic            wr_en_x,
    output logic            wr_bank,
    output logic [LOGN-1:0] addr_x_wr,
    output logic            rd_bank,
    output logic [LOGN-1:0] addr_x_rd,
    output logic [LOGW-1:0] addr_w,
    output logic            clear_acc,
    output logic            en_acc
`ifdef FC_PERF_CNT_EN
    ,
    input  logic            perf_clr,
    output logic [15:0]     stall_cycles
`endif
);

    localparam int LOGM = clog2_min1(M);

    // Both streams transfer on a cycle where valid and ready are both high; a
    // valid holder keeps valid and data stable until that cycle.
    sched_state_t       state, state_n;
    logic [LOGM-1:0]    row, row_n;
    logic [LOGN-1:0]    col, col_n;
    logic [LOGW-1:0]    addr_w_q, cur_addr;
    logic               rd_bank_q, rd_bank_n;
    logic [MAC_LAT-1:0] issue_sr, sr_adv;
    logic [1:0]         bank_full;
    logic               issue, clear_c, release_en;

    fc_xbuf_loader #(.N(N)) u_loader (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .release_en   (release_en),
        .release_bank (rd_bank_q),
        .input_ready  (input_ready),
        .wr_en_x      (wr_en_x),
        .wr_bank      (wr_bank),
        .addr_x_wr    (addr_x_wr),
        .bank_full    (bank_full)
    );

    assign cur_addr     = LOGW'(int'(row) * N + int'(col));
    assign sr_adv       = MAC_LAT'({issue_sr, 1'b0});
    assign addr_w       = (state == RUN) ? cur_addr : addr_w_q;
    assign addr_x_rd    = col;
    assign rd_bank      = rd_bank_q;
    assign en_acc       = issue_sr[MAC_LAT-1];
    assign output_valid = (state == HOLD);
    assign clear_acc    = reset || clear_c;

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        rd_bank_n  = rd_bank_q;
        issue      = 1'b0;
        clear_c    = 1'b0;
        release_en = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rd_bank_q]) begin
                    clear_c = 1'b1;
                    row_n   = '0;
                    col_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (col == LOGN'(N - 1)) begin
                    col_n   = '0;
                    state_n = DRAIN;
                end else begin
                    col_n = col + 1'b1;
                end
            end
            // Leave once the last in-flight product is accumulated this cycle.
            DRAIN: begin
                if (sr_adv == '0) state_n = HOLD;
            end
            HOLD: begin
                if (output_ready) begin
                    clear_c = 1'b1;
                    if (row == LOGM'(M - 1)) begin
                        release_en = 1'b1;
                        rd_bank_n  = ~rd_bank_q;
                        row_n      = '0;
                        state_n    = bank_full[!rd_bank_q] ? RUN : IDLE;
                    end else begin
                        row_n   = row + 1'b1;
                        state_n = RUN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            addr_w_q  <= '0;
            rd_bank_q <= 1'b0;
            issue_sr  <= '0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            col       <= col_n;
            rd_bank_q <= rd_bank_n;
            issue_sr  <= MAC_LAT'({issue_sr, issue});
            if (issue) addr_w_q <= cur_addr;
        end
    end

`ifdef FC_PERF_CNT_EN
    logic [16:0] stall_sum;

    always_comb begin
        stall_sum = {1'b0, stall_cycles}
                  + 17'(output_valid && !output_ready)
                  + 17'(input_valid && !input_ready);
    end

    always_ff @(posedge clk) begin
        if (reset || perf_clr) stall_cycles <= '0;
        else stall_cycles <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
`endif

endmodule
